// File: rtl/scoreboard_display_if.sv
// Bus between the scoreboard RAM reader, the leaderboard stage
// and the seven-segment display pins.
interface scoreboard_display_if;
  logic [1:0]  game_state;
  logic [31:0] sb_data;
  logic        sb_parity;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [3:0]  rank_led;
  logic        field_sel;
  logic [2:0]  entry_count;

  modport master (
    output game_state, sb_data, sb_parity,
    input  seg, an, rank_led, field_sel,
    input  entry_count
  );

  modport slave (
    input  game_state, sb_data, sb_parity,
    output seg, an, rank_led, field_sel,
    output entry_count
  );
endinterface

// File: rtl/scoreboard_display.sv
// Top-4 leaderboard capture, ranking and multiplexed
// seven-segment display of userid / score per rank.
module scoreboard_display #(
  parameter logic [15:0] DIGIT_DIV = 16'd50000,
  parameter logic [31:0] DWELL     = 32'd50_000_000
) (
  input logic                 clk,
  input logic                 rst,
  scoreboard_display_if.slave sb
);

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_ID    = 2'd1;
  localparam logic [1:0] ST_SC    = 2'd2;

  logic             r_par_q;
  logic [1:0]       r_gs_q;
  logic             r_in_vld;
  logic [31:0]      r_in_data;
  logic [3:0][31:0] r_tbl;
  logic [2:0]       r_cnt;
  logic [1:0]       r_st;
  logic [1:0]       r_rank;
  logic [31:0]      r_dwell;
  logic [15:0]      r_ref;
  logic [1:0]       r_dig;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic [3:0]       r_rled;
  logic             r_fsel;

  logic             w_new;
  logic             w_clr;
  logic [2:0]       w_pos;
  logic [3:0][31:0] w_tbl_nx;
  logic [2:0]       w_cnt_nx;
  logic [1:0]       w_st_nx;
  logic [1:0]       w_rank_nx;
  logic [31:0]      w_dwell_nx;
  logic             w_dw_end;
  logic [2:0]       w_rank_inc;
  logic [15:0]      w_ref_nx;
  logic [1:0]       w_dig_nx;
  logic [15:0]      w_field;
  logic [3:0]       w_nib;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'b1000000;
      4'h1: f_hex = 7'b1111001;
      4'h2: f_hex = 7'b0100100;
      4'h3: f_hex = 7'b0110000;
      4'h4: f_hex = 7'b0011001;
      4'h5: f_hex = 7'b0010010;
      4'h6: f_hex = 7'b0000010;
      4'h7: f_hex = 7'b1111000;
      4'h8: f_hex = 7'b0000000;
      4'h9: f_hex = 7'b0010000;
      4'hA: f_hex = 7'b0001000;
      4'hB: f_hex = 7'b0000011;
      4'hC: f_hex = 7'b1000110;
      4'hD: f_hex = 7'b0100001;
      4'hE: f_hex = 7'b0000110;
      default: f_hex = 7'b0001110;
    endcase
  endfunction

  assign w_new = sb.sb_parity != r_par_q;
  assign w_clr = (sb.game_state == 2'b10)
              && (r_gs_q != 2'b10);

  // Ties rank below existing entries, so count >= not >
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < r_cnt &&
          r_tbl[i][15:0] >= r_in_data[15:0])
        w_pos = w_pos + 3'd1;
    end
  end

  always_comb begin
    w_tbl_nx = r_tbl;
    for (int i = 1; i < 4; i++) begin
      if (3'(i) > w_pos)
        w_tbl_nx[i] = r_tbl[2'(i - 1)];
    end
    for (int i = 0; i < 4; i++) begin
      if (3'(i) == w_pos)
        w_tbl_nx[i] = r_in_data;
    end
  end

  assign w_cnt_nx = (w_pos != 3'd4 && r_cnt != 3'd4)
                  ? r_cnt + 3'd1 : r_cnt;

  assign w_dw_end   = r_dwell == DWELL - 32'd1;
  assign w_rank_inc = {1'b0, r_rank} + 3'd1;

  always_comb begin
    w_st_nx    = r_st;
    w_rank_nx  = r_rank;
    w_dwell_nx = r_dwell;
    if (w_clr) begin
      w_st_nx    = ST_BLANK;
      w_rank_nx  = '0;
      w_dwell_nx = '0;
    end else begin
      unique case (1'b1)
        (r_st == ST_BLANK): begin
          if (r_cnt != 3'd0) begin
            w_st_nx    = ST_ID;
            w_rank_nx  = '0;
            w_dwell_nx = '0;
          end
        end
        (r_st == ST_ID): begin
          w_dwell_nx = w_dw_end ? '0 : r_dwell + 32'd1;
          if (w_dw_end)
            w_st_nx = ST_SC;
        end
        (r_st == ST_SC): begin
          w_dwell_nx = w_dw_end ? '0 : r_dwell + 32'd1;
          if (w_dw_end) begin
            w_st_nx   = ST_ID;
            w_rank_nx = (w_rank_inc >= r_cnt)
                      ? 2'd0 : w_rank_inc[1:0];
          end
        end
        default: begin
          w_st_nx    = ST_BLANK;
          w_rank_nx  = '0;
          w_dwell_nx = '0;
        end
      endcase
    end
  end

  assign w_ref_nx = (r_ref == DIGIT_DIV - 16'd1)
                  ? '0 : r_ref + 16'd1;
  assign w_dig_nx = (r_ref == DIGIT_DIV - 16'd1)
                  ? r_dig + 2'd1 : r_dig;

  // Outputs register from next-state values so seg/an
  // and the rank indicator change on the same edge.
  assign w_field = (w_st_nx == ST_SC)
                 ? r_tbl[w_rank_nx][15:0]
                 : r_tbl[w_rank_nx][31:16];
  assign w_nib   = w_field[{w_dig_nx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_q   <= 1'b0;
      r_gs_q    <= '0;
      r_in_vld  <= 1'b0;
      r_in_data <= '0;
      r_tbl     <= '0;
      r_cnt     <= '0;
      r_st      <= ST_BLANK;
      r_rank    <= '0;
      r_dwell   <= '0;
      r_ref     <= '0;
      r_dig     <= '0;
      r_seg     <= 7'h7F;
      r_an      <= 4'hF;
      r_rled    <= '0;
      r_fsel    <= 1'b0;
    end else begin
      r_par_q   <= sb.sb_parity;
      r_gs_q    <= sb.game_state;
      r_in_vld  <= w_new && !w_clr
                && (sb.sb_data[31:16] != 16'h0000);
      r_in_data <= sb.sb_data;
      if (w_clr) begin
        r_tbl <= '0;
        r_cnt <= '0;
      end else if (r_in_vld) begin
        r_tbl <= w_tbl_nx;
        r_cnt <= w_cnt_nx;
      end
      r_st    <= w_st_nx;
      r_rank  <= w_rank_nx;
      r_dwell <= w_dwell_nx;
      r_ref   <= w_ref_nx;
      r_dig   <= w_dig_nx;
      if (w_st_nx == ST_BLANK) begin
        r_seg  <= 7'h7F;
        r_an   <= 4'hF;
        r_rled <= '0;
        r_fsel <= 1'b0;
      end else begin
        r_seg  <= f_hex(w_nib);
        r_an   <= ~(4'b0001 << w_dig_nx);
        r_rled <= 4'b0001 << w_rank_nx;
        r_fsel <= w_st_nx == ST_SC;
      end
    end
  end

  assign sb.seg         = r_seg;
  assign sb.an          = r_an;
  assign sb.rank_led    = r_rled;
  assign sb.field_sel   = r_fsel;
  assign sb.entry_count = r_cnt;

endmodule
